dispense_timer: RTL and testbench

Ingredient dispense timer for the coffee maker. It is the consuming end of the sequencer's `ing_type`/`start_timer` command interface. On each accepted start command it opens the valve for the selected ingredient and holds it open for a per-ingredient duration. When the duration elapses it closes the valve and returns a one-cycle `t_expired` completion pulse to the sequencer.

---
 rtl/dispense_timer.sv | 172 +++++++++++++++++
 tb/tb_dispense_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dispense_timer.sv
// Ingredient dispense timer: opens one valve for a per-ingredient number of
// time units on each start command and pulses t_expired when the time runs out.
module dispense_timer #(
  parameter int CLK_DIV   = 50000000,
  parameter int PRESC_W   = 26,
  parameter int CNT_W     = 8,
  parameter int DUR_AGUA  = 10,
  parameter int DUR_CAFE  = 5,
  parameter int DUR_MILK  = 4,
  parameter int DUR_CHOCO = 3,
  parameter int DUR_AZUC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [2:0]       ing_type,
  input  logic             abort,
  output logic [4:0]       valve,
  output logic             busy,
  output logic             t_expired,
  output logic [CNT_W-1:0] remaining,
  output logic             err,
  output logic             ovr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               start_prev_r;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] presc_s;
  logic [4:0]         valve_s;
  logic               busy_s;
  logic               t_expired_s;
  logic [CNT_W-1:0]   remaining_s;
  logic               err_s;
  logic               ovr_s;
  logic               start_edge_s;
  logic               code_valid_s;
  logic [CNT_W-1:0]   code_dur_s;
  logic               tick_s;

  function automatic logic [4:0] valve_of(input logic [2:0] code);
    logic [4:0] v;
    case (code)
      3'd0:    v = 5'b10000;
      3'd1:    v = 5'b01000;
      3'd2:    v = 5'b00100;
      3'd3:    v = 5'b00010;
      3'd4:    v = 5'b00001;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] code);
    logic [CNT_W-1:0] d;
    case (code)
      3'd0:    d = CNT_W'(DUR_AGUA);
      3'd1:    d = CNT_W'(DUR_CAFE);
      3'd2:    d = CNT_W'(DUR_MILK);
      3'd3:    d = CNT_W'(DUR_CHOCO);
      3'd4:    d = CNT_W'(DUR_AZUC);
      default: d = {CNT_W{1'b0}};
    endcase
    return d;
  endfunction

  assign start_edge_s = start_timer & ~start_prev_r;
  assign code_valid_s = (ing_type <= 3'd4);
  assign code_dur_s   = dur_of(ing_type);
  assign tick_s       = (presc_r == PRESC_W'(CLK_DIV - 1));

  // Next-state and next-output decode; abort has priority inside RUN.
  always_comb begin
    state_s     = state_r;
    presc_s     = presc_r;
    valve_s     = valve;
    busy_s      = busy;
    t_expired_s = 1'b0;
    remaining_s = remaining;
    err_s       = err;
    ovr_s       = ovr;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_edge_s) begin
          if (!code_valid_s) begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end else if (code_dur_s == {CNT_W{1'b0}}) begin
            t_expired_s = 1'b1;
            state_s     = ST_DONE;
          end else begin
            remaining_s = code_dur_s;
            presc_s     = {PRESC_W{1'b0}};
            valve_s     = valve_of(ing_type);
            busy_s      = 1'b1;
            state_s     = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start_edge_s) begin
          ovr_s = 1'b1;
        end else begin
          ovr_s = ovr;
        end
        if (abort) begin
          valve_s     = 5'b00000;
          busy_s      = 1'b0;
          remaining_s = {CNT_W{1'b0}};
          presc_s     = {PRESC_W{1'b0}};
          state_s     = ST_IDLE;
        end else if (tick_s) begin
          presc_s = {PRESC_W{1'b0}};
          // remaining is always >= 1 in RUN; the guard keeps it from wrapping
          if (remaining <= CNT_W'(1)) begin
            remaining_s = {CNT_W{1'b0}};
            valve_s     = 5'b00000;
            busy_s      = 1'b0;
            t_expired_s = 1'b1;
            state_s     = ST_DONE;
          end else begin
            remaining_s = remaining - CNT_W'(1);
          end
        end else begin
          presc_s = presc_r + PRESC_W'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        presc_s     = {PRESC_W{1'b0}};
        valve_s     = 5'b00000;
        busy_s      = 1'b0;
        remaining_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, edge-detector and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      start_prev_r <= 1'b0;
      presc_r      <= {PRESC_W{1'b0}};
      valve        <= 5'b00000;
      busy         <= 1'b0;
      t_expired    <= 1'b0;
      remaining    <= {CNT_W{1'b0}};
      err          <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      state_r      <= state_s;
      start_prev_r <= start_timer;
      presc_r      <= presc_s;
      valve        <= valve_s;
      busy         <= busy_s;
      t_expired    <= t_expired_s;
      remaining    <= remaining_s;
      err          <= err_s;
      ovr          <= ovr_s;
    end
  end

endmodule

// File: tb/tb_dispense_timer.sv
// Self-checking bench for dispense_timer: directed scenarios followed by random
// stimulus, every output compared each cycle against a time-based reference model.
module tb_dispense_timer;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             reset;
  logic             start_timer;
  logic [2:0]       ing_type;
  logic             abort;
  logic [4:0]       valve;
  logic             busy;
  logic             t_expired;
  logic [CNT_W-1:0] remaining;
  logic             err;
  logic             ovr;

  dispense_timer #(
    .CLK_DIV(CLK_DIV), .PRESC_W(8), .CNT_W(CNT_W),
    .DUR_AGUA(3), .DUR_CAFE(2), .DUR_MILK(1), .DUR_CHOCO(0), .DUR_AZUC(5)
  ) dut (
    .clk(clk), .reset(reset), .start_timer(start_timer), .ing_type(ing_type),
    .abort(abort), .valve(valve), .busy(busy), .t_expired(t_expired),
    .remaining(remaining), .err(err), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a dispense is described by its code, its length and the
  // number of clock edges elapsed since the accepting edge.
  int         dur_tab [8] = '{3, 2, 1, 0, 5, 0, 0, 0};
  logic [4:0] valve_tab [5] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
  bit         m_prev, m_active, m_texp, m_err, m_ovr;
  int         m_code, m_dur, m_n, m_rem;
  int         n_checks, n_fail;

  task automatic model_edge();
    bit edge_seen;
    bit texp_next;
    texp_next = 1'b0;
    if (reset) begin
      m_prev = 1'b0; m_active = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_rem = 0;
    end else begin
      edge_seen = start_timer && !m_prev;
      m_prev    = start_timer;
      if (m_active) begin
        if (edge_seen) m_ovr = 1'b1;
        if (abort) begin
          m_active = 1'b0;
          m_rem    = 0;
        end else begin
          m_n   = m_n + 1;
          m_rem = m_dur - m_n / CLK_DIV;
          if (m_n == m_dur * CLK_DIV) begin
            m_active  = 1'b0;
            texp_next = 1'b1;
          end
        end
      end else if (edge_seen) begin
        if (ing_type > 3'd4) begin
          m_err = 1'b1;
        end else if (dur_tab[ing_type] == 0) begin
          texp_next = 1'b1;
        end else begin
          m_active = 1'b1;
          m_code   = int'(ing_type);
          m_dur    = dur_tab[ing_type];
          m_n      = 0;
          m_rem    = m_dur;
        end
      end
    end
    m_texp = texp_next;
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    logic [4:0] exp_valve;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      exp_valve = m_active ? valve_tab[m_code] : 5'b00000;
      chk("valve",     int'(valve),     int'(exp_valve));
      chk("busy",      int'(busy),      int'(m_active));
      chk("t_expired", int'(t_expired), int'(m_texp));
      chk("remaining", int'(remaining), m_rem);
      chk("err",       int'(err),       int'(m_err));
      chk("ovr",       int'(ovr),       int'(m_ovr));
    end
  endtask

  task automatic pulse(input logic [2:0] code);
    ing_type    = code;
    start_timer = 1'b1;
    cyc(1);
    start_timer = 1'b0;
    ing_type    = 3'($urandom_range(0, 7));
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_prev = 1'b0; m_active = 1'b0; m_texp = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    m_code = 0; m_dur = 0; m_n = 0; m_rem = 0;
    reset = 1'b1; start_timer = 1'b0; ing_type = 3'd0; abort = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);

    // agua: 12 cycles of valve, then one t_expired
    pulse(3'd0); cyc(16);
    // zero-duration choco
    pulse(3'd3); cyc(3);
    // invalid code, then milk with err held
    pulse(3'd6); cyc(3);
    pulse(3'd2); cyc(7);
    // overrun: second edge 3 cycles into cafe
    pulse(3'd1); cyc(2);
    pulse(3'd4); cyc(10);
    // abort during azuc, then a normal agua
    pulse(3'd4); cyc(6);
    abort = 1'b1; cyc(1);
    abort = 1'b0; cyc(3);
    pulse(3'd0); cyc(14);
    // abort coinciding with a start edge inside RUN
    pulse(3'd1); cyc(2);
    abort = 1'b1; ing_type = 3'd0; start_timer = 1'b1; cyc(1);
    abort = 1'b0; start_timer = 1'b0; cyc(3);
    // reset mid-run, start held high through reset release
    pulse(3'd0); cyc(5);
    reset = 1'b1; cyc(1);
    start_timer = 1'b1; ing_type = 3'd2; cyc(1);
    reset = 1'b0; cyc(7);
    start_timer = 1'b0; cyc(2);
    // back-to-back: new start in the t_expired cycle
    pulse(3'd0); cyc(12);
    chk("texp_before_b2b", int'(t_expired), 1);
    pulse(3'd1);
    chk("b2b_accepted", int'(busy), 1);
    cyc(10);
    // back-to-back into a zero-duration command
    pulse(3'd2); cyc(3);
    pulse(3'd3); cyc(3);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      start_timer = ($urandom_range(0, 3) == 0);
      ing_type    = 3'($urandom_range(0, 7));
      abort       = ($urandom_range(0, 29) == 0);
      reset       = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    reset = 1'b0; abort = 1'b0; start_timer = 1'b0;
    cyc(25);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
